dcache_write_buffer: RTL and testbench

//  Posted-write FIFO between the data cache and data memory. Accepts 32-bit block write-backs from the

---
 rtl/dcache_write_buffer.sv | 222 ++++++++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//   Posted-write FIFO between the data cache and data memory. Block
//   write-backs from the dcache are accepted in one cycle and drained to
//   memory in the background, one memory operation at a time. Reads are
//   forwarded to memory without reordering them against buffered writes to
//   the same block.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   c_read, c_write     dcache requests, held until c_busywait is low
//   c_address           dcache block address
//   c_writedata         dcache write block
//   c_readdata          read block to the dcache (registered, valid while rd_done)
//   c_busywait          stall to the dcache (combinational)
//   mem_read/mem_write  data-memory strobes (registered)
//   mem_address         data-memory block address (registered)
//   mem_writedata       data-memory write block (registered)
//   mem_readdata        data-memory read block
//   mem_busywait        data-memory busy; an op completes at the edge it is low
//
// Configuration
//   WBUF_FORWARD_EN  when defined, a read that hits a buffered block is served
//                    from the buffer in one cycle with no memory read.
//                    When undefined, such a read waits until every matching
//                    entry has drained and then reads memory.
module dcache_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 6,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          c_read,
  input  logic          c_write,
  input  logic [AW-1:0] c_address,
  input  logic [DW-1:0] c_writedata,
  output logic [DW-1:0] c_readdata,
  output logic          c_busywait,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writedata,
  input  logic [DW-1:0] mem_readdata,
  input  logic          mem_busywait
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_READ} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW-1:0]    addr_q [DEPTH];
  logic [AW-1:0]    addr_d [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_done_q, rd_done_d;
  logic [DW-1:0]    c_readdata_q, c_readdata_d;
  logic             mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [AW-1:0]    mem_address_q, mem_address_d;
  logic [DW-1:0]    mem_writedata_q, mem_writedata_d;

  logic             hit_new, hit_head;
  logic [PW-1:0]    hit_idx;
  logic             read_pending, write_ok, write_accept;
  logic             push, pop;
  logic             fwd_hit, read_issue_ok;
  logic [DW-1:0]    fwd_data;

  // Address match. The head entry being drained is tracked separately: its
  // data was already snapshotted, so a write to it must open a new tail entry
  // rather than coalesce into it.
  always_comb begin
    hit_new  = 1'b0;
    hit_head = 1'b0;
    hit_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == c_address)) begin
        if ((state_q == S_DRAIN) && (PW'(i) == rd_ptr_q)) begin
          hit_head = 1'b1;
        end else begin
          hit_new = 1'b1;
          hit_idx = PW'(i);
        end
      end
    end
  end

  assign read_pending = c_read & ~rd_done_q;
  assign write_ok     = (count_q != FULL) | hit_new;
  // A read always wins over a simultaneous write.
  assign write_accept = c_write & ~c_read & write_ok;
  assign c_busywait   = c_read ? ~rd_done_q : (c_write & ~write_ok);

`ifdef WBUF_FORWARD_EN
  // The youngest copy of a block is a non-head match if one exists.
  assign fwd_hit       = hit_new | hit_head;
  assign fwd_data      = hit_new ? data_q[hit_idx] : data_q[rd_ptr_q];
  assign read_issue_ok = ~fwd_hit;
`else
  assign fwd_hit       = 1'b0;
  assign fwd_data      = '0;
  assign read_issue_ok = ~(hit_new | hit_head);
`endif

  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    addr_d          = addr_q;
    data_d          = data_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    rd_done_d       = 1'b0;
    c_readdata_d    = c_readdata_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;

    push = write_accept & ~hit_new;
    pop  = (state_q == S_DRAIN) & ~mem_busywait;

    if (write_accept) begin
      if (hit_new) begin
        data_d[hit_idx] = c_writedata;
      end else begin
        valid_d[wr_ptr_q] = 1'b1;
        addr_d[wr_ptr_q]  = c_address;
        data_d[wr_ptr_q]  = c_writedata;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (read_pending && fwd_hit && (state_q != S_READ)) begin
      c_readdata_d = fwd_data;
      rd_done_d    = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (read_pending && read_issue_ok) begin
          state_d       = S_READ;
          mem_read_d    = 1'b1;
          mem_address_d = c_address;
        end else if (count_q != '0) begin
          state_d       = S_DRAIN;
          mem_write_d   = 1'b1;
          mem_address_d = addr_q[rd_ptr_q];
          // A write coalescing into the head on this same edge must be the
          // data that reaches memory, since the head is popped afterwards.
          mem_writedata_d = (write_accept && hit_new && (hit_idx == rd_ptr_q)) ?
                            c_writedata : data_q[rd_ptr_q];
        end
      end
      S_DRAIN: begin
        if (!mem_busywait) begin
          state_d     = S_IDLE;
          mem_write_d = 1'b0;
        end
      end
      S_READ: begin
        if (!mem_busywait) begin
          state_d      = S_IDLE;
          mem_read_d   = 1'b0;
          c_readdata_d = mem_readdata;
          rd_done_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= S_IDLE;
      valid_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      rd_done_q       <= 1'b0;
      c_readdata_q    <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      rd_done_q       <= rd_done_d;
      c_readdata_q    <= c_readdata_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
    end
  end

  // Entry payload is qualified by valid_q and needs no reset.
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign c_readdata    = c_readdata_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Directed bench for dcache_write_buffer with a behavioural data memory of
// programmable latency that logs every completed write.
module tb_dcache_write_buffer;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        c_read, c_write;
  logic [5:0]  c_address;
  logic [31:0] c_writedata, c_readdata;
  logic        c_busywait;
  logic        mem_read, mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic        mem_busywait;

  dcache_write_buffer #(.DEPTH(4), .AW(6), .DW(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .c_read(c_read), .c_write(c_write), .c_address(c_address),
    .c_writedata(c_writedata), .c_readdata(c_readdata), .c_busywait(c_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait)
  );

  always #5 CLK = ~CLK;

  // Behavioural memory: an op completes at the lat-th edge after issue.
  // Unwritten blocks read back as C0DE0000 | address.
  int          lat = 4;
  int          lat_cnt = 0;
  logic [31:0] mem [64];
  logic [63:0] mem_vld;
  logic [5:0]  wlog_a[$];
  logic [31:0] wlog_d[$];
  int          rd_starts = 0;
  bit          mr_prev = 1'b0;

  assign mem_busywait = (mem_read | mem_write) && (lat_cnt != lat - 1);
  assign mem_readdata = mem_vld[mem_address] ? mem[mem_address]
                                             : (32'hC0DE_0000 | 32'(mem_address));

  always @(posedge CLK) begin
    mr_prev <= mem_read;
    if (mem_read && !mr_prev) rd_starts <= rd_starts + 1;
    if (RESET) mem_vld <= '0;
    if (mem_read | mem_write) begin
      if (lat_cnt == lat - 1) begin
        lat_cnt <= 0;
        if (mem_write) begin
          mem[mem_address]     <= mem_writedata;
          mem_vld[mem_address] <= 1'b1;
          wlog_a.push_back(mem_address);
          wlog_d.push_back(mem_writedata);
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d, output int stalls);
    stalls      = 0;
    c_write     = 1'b1;
    c_address   = a;
    c_writedata = d;
    @(negedge CLK);
    while (c_busywait && stalls < 500) begin
      stalls++;
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    c_write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d, output int cycles);
    cycles    = 0;
    c_read    = 1'b1;
    c_address = a;
    @(negedge CLK);
    while (c_busywait && cycles < 2000) begin
      cycles++;
      @(negedge CLK);
    end
    d = c_readdata;
    @(posedge CLK); #1;
    c_read = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int t;
    t = 0;
    while (wlog_a.size() < n && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    check(tag, 32'(t < 3000), 32'd1);
    @(posedge CLK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st, cyc, base, t, starts0;
    bit          seen;
    logic [31:0] rdat;

    RESET = 1'b1; c_read = 1'b0; c_write = 1'b0;
    c_address = '0; c_writedata = '0;
    repeat (2) @(posedge CLK); #1;
    check("rst_mem_read",   32'(mem_read),  32'd0);
    check("rst_mem_write",  32'(mem_write), 32'd0);
    check("rst_busywait",   32'(c_busywait), 32'd0);
    check("rst_readdata",   c_readdata, 32'd0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // T1: reset during a drain discards the entry
    lat  = 20;
    base = wlog_a.size();
    wr(6'd10, 32'h1010_1010, st);
    t = 0;
    while (!mem_write && t < 50) begin @(posedge CLK); #1; t++; end
    check("t1_drain_started", 32'(mem_write), 32'd1);
    repeat (3) @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("t1_mem_write",     32'(mem_write), 32'd0);
    check("t1_mem_read",      32'(mem_read),  32'd0);
    check("t1_mem_address",   32'(mem_address), 32'd0);
    check("t1_mem_writedata", mem_writedata, 32'd0);
    check("t1_readdata",      c_readdata, 32'd0);
    seen = 1'b0;
    repeat (30) begin @(posedge CLK); #1; if (mem_write) seen = 1'b1; end
    check("t1_no_writeback", 32'(seen), 32'd0);
    check("t1_log_empty",    32'(wlog_a.size() - base), 32'd0);

    // T2: fill four entries, fifth stalls until the first pop
    lat  = 40;
    base = wlog_a.size();
    for (int i = 1; i <= 4; i++) begin
      wr(6'(i), 32'hA0 + 32'(i), st);
      check($sformatf("t2_w%0d_nostall", i), 32'(st), 32'd0);
    end
    wr(6'd5, 32'hA5, st);
    check("t2_w5_stalled", 32'(st > 0), 32'd1);
    wait_writes(base + 5, "t2_drain_done");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_addr%0d", i), 32'(wlog_a[base + i]), 32'(i + 1));
      check($sformatf("t2_data%0d", i), wlog_d[base + i], 32'hA1 + 32'(i));
    end

    // T3: coalesce into a buffered entry while full
    lat  = 10;
    base = wlog_a.size();
    wr(6'd20, 32'h20, st);
    wr(6'd21, 32'h21, st);
    wr(6'd22, 32'h22, st);
    wr(6'd7, 32'h11, st);
    check("t3_first7_nostall", 32'(st), 32'd0);
    wr(6'd7, 32'h22, st);
    check("t3_coalesce_nostall", 32'(st), 32'd0);
    wait_writes(base + 4, "t3_drain_done");
    repeat (30) @(posedge CLK); #1;
    check("t3_write_count", 32'(wlog_a.size() - base), 32'd4);
    check("t3_last_addr",   32'(wlog_a[base + 3]), 32'd7);
    check("t3_last_data",   wlog_d[base + 3], 32'h22);
    check("t3_head_addr",   32'(wlog_a[base]), 32'd20);

    // T4: read after write to the same block
    base    = wlog_a.size();
    starts0 = rd_starts;
    wr(6'd9, 32'hDEAD_BEEF, st);
    rd(6'd9, rdat, cyc);
    check("t4_readdata", rdat, 32'hDEAD_BEEF);
`ifdef WBUF_FORWARD_EN
    check("t4_fwd_latency", 32'(cyc), 32'd1);
    check("t4_no_mem_read", 32'(rd_starts - starts0), 32'd0);
    wait_writes(base + 1, "t4_drain_done");
`else
    check("t4_drained_first", 32'(wlog_a.size() - base), 32'd1);
    check("t4_one_mem_read",  32'(rd_starts - starts0), 32'd1);
`endif
    repeat (3) @(posedge CLK); #1;

    // T5: non-matching read bypasses a buffered write
    base    = wlog_a.size();
    starts0 = rd_starts;
    wr(6'd3, 32'h33, st);
    rd(6'd12, rdat, cyc);
    check("t5_readdata",     rdat, 32'hC0DE_000C);
    check("t5_read_first",   32'(wlog_a.size() - base), 32'd0);
    check("t5_one_mem_read", 32'(rd_starts - starts0), 32'd1);
    wait_writes(base + 1, "t5_drain_done");
    check("t5_drain_addr", 32'(wlog_a[base]), 32'd3);
    check("t5_drain_data", wlog_d[base], 32'h33);

    // T6: stream with concurrent push and pop, pointers wrap
    lat  = 1;
    base = wlog_a.size();
    for (int i = 0; i < 12; i++) wr(6'(32 + i), 32'h6000_0000 + 32'(i), st);
    wait_writes(base + 12, "t6_drain_done");
    repeat (10) @(posedge CLK); #1;
    check("t6_write_count", 32'(wlog_a.size() - base), 32'd12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t6_addr%0d", i), 32'(wlog_a[base + i]), 32'(32 + i));
      check($sformatf("t6_data%0d", i), wlog_d[base + i], 32'h6000_0000 + 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
